// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - request/serial-line signal bundle for uart_transmitter
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx;

    modport master (
        output tick, tx_start, tx_data,
        input  tx_busy, tx_done, tx
    );

    modport slave (
        input  tick, tx_start, tx_data,
        output tx_busy, tx_done, tx
    );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser (start, LSB-first data, optional parity under UART_TX_PARITY_EN, stop)
module uart_transmitter #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    uart_transmitter_if.slave bus
);
    localparam int S_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int N_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_transmitter: DATA_BITS must be 5..8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Next-state, counter and line-level logic; tx is registered from the next state so it tracks state_q.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.tx_start) begin
                    shift_d  = bus.tx_data;
                    s_d      = '0;
                    n_d      = '0;
                    state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^bus.tx_data) ^ PARITY_ODD[0];
`endif
                end
            end
            ST_START: begin
                if (bus.tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == N_W'(DATA_BITS - 1)) begin
                            n_d = '0;
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bus.tick) begin
                    if (s_q == S_W'(15)) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (bus.tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces an idle, high line at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            n_q      <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter against a tick-count frame model
module tb_uart_transmitter;
    localparam int DB   = 8;
    localparam int SBT  = 16;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FT = 16 * (1 + DB + PB) + SBT;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_transmitter_if #(.DATA_BITS(DB)) bus ();

    uart_transmitter #(
        .DATA_BITS (DB),
        .SB_TICK   (SBT),
        .PARITY_ODD(PODD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: line high, not busy, no done pulse, random ticks.
    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.tick     = 1'($urandom_range(0, 1));
            bus.tx_start = 1'b0;
            chk("idle_tx", i, bus.tx, 1'b1);
            chk("idle_busy", i, bus.tx_busy, 1'b0);
            chk("idle_done", i, bus.tx_done, 1'b0);
            next_cycle();
        end
    endtask

    // Caller has already driven the accept cycle (tx_start=1, tx_data=data).
    // Expected line value comes from the number of ticks seen since the accept cycle:
    // each 16 ticks advance one frame bit; the frame ends after FT ticks.
    // period 0 = random ticks, otherwise one tick every period-th cycle of the frame.
    task automatic frame(input logic [DB-1:0] data, input int period, input bit hold,
                         input int glitch_c, input bit nxt, input logic [DB-1:0] nxt_data,
                         output int done_c);
        bit bits[$];
        int ticks;
        int c;
        bit t;
        logic exp_tx;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^data) ^ PODD[0]);
`endif
        next_cycle();
        c      = 1;
        ticks  = 0;
        done_c = -1;
        while (c < 20000) begin
            t = (period == 0) ? ($urandom_range(0, 2) == 0) : ((c % period) == 0);
            bus.tick = t;
            if (ticks >= FT) begin
                chk("end_tx", c, bus.tx, 1'b1);
                chk("end_done", c, bus.tx_done, 1'b1);
                chk("end_busy", c, bus.tx_busy, 1'b0);
                bus.tx_start = nxt;
                bus.tx_data  = nxt_data;
                done_c = c;
                break;
            end
            exp_tx = (ticks / 16 < bits.size()) ? bits[ticks/16] : 1'b1;
            chk("frame_tx", c, bus.tx, exp_tx);
            chk("frame_busy", c, bus.tx_busy, 1'b1);
            chk("frame_done", c, bus.tx_done, 1'b0);
            if (c == glitch_c) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = '1;
            end else begin
                bus.tx_start = hold;
                bus.tx_data  = hold ? data : DB'($urandom);
            end
            ticks += int'(t);
            next_cycle();
            c++;
        end
        if (done_c < 0) chk("frame_timeout", c, 1'b0, 1'b1);
    endtask

    task automatic begin_frame(input logic [DB-1:0] d, input bit t);
        bus.tx_start = 1'b1;
        bus.tx_data  = d;
        bus.tick     = t;
    endtask

    initial begin
        int dc;
        logic [DB-1:0] rd;
        int rp;
        bus.tick     = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;

        // Reset state
        repeat (3) next_cycle();
        chk("rst_tx", 0, bus.tx, 1'b1);
        chk("rst_busy", 0, bus.tx_busy, 1'b0);
        chk("rst_done", 0, bus.tx_done, 1'b0);
        reset = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of the data bits
        begin_frame(8'h00, 1'b1);
        next_cycle();
        bus.tx_start = 1'b0;
        repeat (39) next_cycle();
        chk("pre_rst_tx", 40, bus.tx, 1'b0);
        chk("pre_rst_busy", 40, bus.tx_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx", 40, bus.tx, 1'b1);
        chk("async_rst_busy", 40, bus.tx_busy, 1'b0);
        chk("async_rst_done", 40, bus.tx_done, 1'b0);
        next_cycle();
        reset = 1'b0;
        idle(20);

        // tick tied high, 8'hA5
        begin_frame(8'hA5, 1'b1);
        frame(8'hA5, 1, 1'b0, -1, 1'b0, 8'h00, dc);
        chk_int("len_tick1", dc, FT + 1);
        next_cycle();
        idle(4);

        // tick every 4th cycle, 8'h00
        begin_frame(8'h00, 1'b0);
        frame(8'h00, 4, 1'b0, -1, 1'b0, 8'h00, dc);
        chk_int("len_tick4", dc, FT * 4 + 1);
        next_cycle();
        idle(4);

        // Mid-frame re-request with 8'hFF is ignored
        begin_frame(8'h3C, 1'b1);
        frame(8'h3C, 1, 1'b0, 50, 1'b0, 8'h00, dc);
        next_cycle();
        idle(40);

        // tx_start held high: 8'h55 then 8'hAA back-to-back
        begin_frame(8'h55, 1'b1);
        frame(8'h55, 1, 1'b1, -1, 1'b1, 8'hAA, dc);
        frame(8'hAA, 1, 1'b0, -1, 1'b0, 8'h00, dc);
        chk_int("len_b2b", dc, FT + 1);
        next_cycle();
        idle(4);

        // Parity-relevant byte
        begin_frame(8'h07, 1'b0);
        frame(8'h07, 2, 1'b0, -1, 1'b0, 8'h00, dc);
        chk_int("len_07", dc, FT * 2 + 1);
        next_cycle();
        idle(4);

        // Random bytes with random or periodic ticks
        for (int k = 0; k < 5; k++) begin
            rd = DB'($urandom);
            rp = int'($urandom_range(0, 3));
            begin_frame(rd, 1'($urandom_range(0, 1)));
            frame(rd, rp, 1'b0, -1, 1'b0, 8'h00, dc);
            if (rp != 0) chk_int("len_rand", dc, FT * rp + 1);
            next_cycle();
            idle(int'($urandom_range(1, 6)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
